run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 24 ++
 rtl/run_ctrl_sat_counter.sv | 31 +++
 rtl/run_ctrl.sv | 157 +++++++++++++++
 tb/tb_run_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM state encoding, stop-mode codes
// and a width helper for the small phase counters.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_HOLD  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_SEL   = 3'd3,
      ST_OUT   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [1:0] MODE_CYCLE  = 2'd0;
   localparam logic [1:0] MODE_RETIRE = 2'd1;
   localparam logic [1:0] MODE_PC     = 2'd2;
   localparam logic [1:0] MODE_ANY    = 2'd3;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the CPU in reset, runs it until a stop condition,
// lets the pipeline drain, then streams out the register file one beat at a time.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int NREGS        = 32,
   parameter int SEL_W        = 5,
   parameter int RESET_CYCLES = 2,
   parameter int DRAIN_CYCLES = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       stop_mode,
   input  logic [CNT_W-1:0] stop_limit,
   input  logic [31:0]      stop_pc,
   input  logic [31:0]      pc,
   input  logic             retire,
   output logic             cpu_rstn,
   output logic             cpu_stall,
   output logic [SEL_W-1:0] reg_sel,
   input  logic [31:0]      reg_data,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [SEL_W-1:0] dump_idx,
   output logic [31:0]      dump_data,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             done
);

   localparam int HOLD_W  = cnt_width(RESET_CYCLES);
   localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);

   state_t             state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [SEL_W-1:0]   dump_idx_q, dump_idx_d;
   logic [31:0]        dump_data_q, dump_data_d;
   logic               count_en;
   logic               cyc_hit, ret_hit, pc_hit, stop_hit;

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .en    (count_en),
      .count (cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_retire_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .en    (count_en & retire),
      .count (retire_cnt)
   );

   // A zero limit disables the count-based stops; otherwise the limit-1 compare
   // means the stopping cycle itself lands the counter exactly on the limit.
   always_comb begin
      cyc_hit  = (stop_limit != '0) && (cycle_cnt == stop_limit - CNT_W'(1));
      ret_hit  = (stop_limit != '0) && retire && (retire_cnt == stop_limit - CNT_W'(1));
      pc_hit   = (pc == stop_pc);
      stop_hit = 1'b0;
      case (stop_mode)
         MODE_CYCLE:  stop_hit = cyc_hit;
         MODE_RETIRE: stop_hit = ret_hit;
         MODE_PC:     stop_hit = pc_hit;
         MODE_ANY:    stop_hit = cyc_hit | ret_hit | pc_hit;
         default:     stop_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      drain_d     = drain_q;
      idx_d       = idx_q;
      dump_idx_d  = dump_idx_q;
      dump_data_d = dump_data_q;
      count_en    = 1'b0;
      case (state_q)
         ST_HOLD: begin
            if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
               state_d = ST_RUN;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         ST_RUN: begin
            count_en = 1'b1;
            if (stop_hit) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end
         end
         ST_DRAIN: begin
            count_en = 1'b1;
            if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
               state_d = ST_SEL;
               idx_d   = '0;
            end else begin
               drain_d = drain_q + DRAIN_W'(1);
            end
         end
         ST_SEL: begin
            // Register 0 is hardwired to zero in the CPU, so report it as such.
            dump_idx_d  = idx_q;
            dump_data_d = (idx_q == '0) ? 32'h0 : reg_data;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (dump_ready) begin
               if (idx_q == SEL_W'(NREGS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + SEL_W'(1);
                  state_d = ST_SEL;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_HOLD;
         hold_q      <= '0;
         drain_q     <= '0;
         idx_q       <= '0;
         dump_idx_q  <= '0;
         dump_data_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         drain_q     <= drain_d;
         idx_q       <= idx_d;
         dump_idx_q  <= dump_idx_d;
         dump_data_q <= dump_data_d;
      end
   end

   assign cpu_rstn   = (state_q != ST_HOLD);
   assign cpu_stall  = (state_q == ST_SEL) || (state_q == ST_OUT) || (state_q == ST_DONE);
   assign reg_sel    = idx_q;
   assign dump_valid = (state_q == ST_OUT);
   assign dump_idx   = dump_idx_q;
   assign dump_data  = dump_data_q;
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a table of stop scenarios plus hand-written
// dump sequences covering ready stalls and a reset mid-dump.
module tb_run_ctrl;

   localparam int NREGS = 32;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] limit;
      logic [31:0] spc;
      int          pc_hit;
      int          ret_pat;
      int          exp_cyc;
      int          exp_ret;
      bit          never;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [1:0]  stop_mode = 2'd0;
   logic [31:0] stop_limit = 32'd0;
   logic [31:0] stop_pc = 32'h40;
   logic [31:0] pc = 32'h7000;
   logic        retire = 1'b0;
   logic        dump_ready = 1'b1;
   logic        cpu_rstn, cpu_stall, dump_valid, done;
   logic [4:0]  reg_sel, dump_idx;
   logic [31:0] reg_data, dump_data, cycle_cnt, retire_cnt;

   logic        s_cpu_rstn, s_cpu_stall, s_dump_valid, s_done;
   logic [1:0]  s_reg_sel, s_dump_idx;
   logic [31:0] s_dump_data;
   logic [3:0]  s_cycle_cnt, s_retire_cnt;

   int pass_cnt = 0;
   int check_cnt = 0;
   vec_t vecs[7];

   always #5 clk = ~clk;

   assign reg_data = 32'h1000 + {27'b0, reg_sel};

   run_ctrl dut (
      .clk(clk), .rstn(rstn), .stop_mode(stop_mode), .stop_limit(stop_limit),
      .stop_pc(stop_pc), .pc(pc), .retire(retire), .cpu_rstn(cpu_rstn),
      .cpu_stall(cpu_stall), .reg_sel(reg_sel), .reg_data(reg_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
      .dump_data(dump_data), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
      .done(done)
   );

   // Narrow instance that never stops, used to watch the counters saturate.
   run_ctrl #(.CNT_W(4), .NREGS(4), .SEL_W(2)) dut_small (
      .clk(clk), .rstn(rstn), .stop_mode(2'd0), .stop_limit(4'd0),
      .stop_pc(32'hFFFF_FFFF), .pc(32'h0), .retire(1'b1), .cpu_rstn(s_cpu_rstn),
      .cpu_stall(s_cpu_stall), .reg_sel(s_reg_sel), .reg_data(32'h0),
      .dump_valid(s_dump_valid), .dump_ready(1'b1), .dump_idx(s_dump_idx),
      .dump_data(s_dump_data), .cycle_cnt(s_cycle_cnt), .retire_cnt(s_retire_cnt),
      .done(s_done)
   );

   function automatic logic [31:0] expData(input int i);
      return (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic checkResetState();
      checkOutput("rst_cpu_rstn", cpu_rstn, 0);
      checkOutput("rst_cpu_stall", cpu_stall, 0);
      checkOutput("rst_reg_sel", reg_sel, 0);
      checkOutput("rst_dump_valid", dump_valid, 0);
      checkOutput("rst_dump_idx", dump_idx, 0);
      checkOutput("rst_dump_data", dump_data, 0);
      checkOutput("rst_cycle_cnt", cycle_cnt, 0);
      checkOutput("rst_retire_cnt", retire_cnt, 0);
      checkOutput("rst_done", done, 0);
   endtask

   // Returns at the falling edge of the first RUN cycle.
   task automatic resetDut();
      @(negedge clk);
      rstn = 1'b0; pc = 32'h7000; retire = 1'b0; dump_ready = 1'b1;
      #2;
      checkResetState();
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checkOutput("hold_cpu_rstn", cpu_rstn, 0);
      checkOutput("hold_cpu_stall", cpu_stall, 0);
      @(negedge clk);
      checkOutput("run_cpu_rstn", cpu_rstn, 1);
   endtask

   task automatic applyStimulus(input vec_t v);
      int k;
      int budget;
      stop_mode = v.mode; stop_limit = v.limit; stop_pc = v.spc;
      resetDut();
      k = 0;
      budget = v.never ? 300 : 1000;
      while (!cpu_stall && k < budget) begin
         pc = (k == v.pc_hit) ? v.spc : 32'h8000 + 32'(k * 4);
         retire = (v.ret_pat == 2) || (v.ret_pat == 1 && (k % 2) == 1);
         k++;
         @(negedge clk);
      end
      retire = 1'b0;
      if (v.never) checkOutput("never_stall", cpu_stall, 0);
      checkOutput("stop_edges", 64'(k), 64'(v.exp_cyc));
      checkOutput("stop_cycle_cnt", cycle_cnt, 64'(v.exp_cyc));
      checkOutput("stop_retire_cnt", retire_cnt, 64'(v.exp_ret));
   endtask

   task automatic runDump(input int stall_idx, input int stall_len, input int abort_idx,
                          output bit aborted);
      int nb;
      int left;
      bit stalled;
      bit last;
      nb = 0; left = 0; stalled = 0; last = 0; aborted = 0;
      dump_ready = 1'b1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         if (last) begin
            checkOutput("done_after_last", done, 1);
            break;
         end
         if (abort_idx >= 0 && dump_valid && dump_idx == abort_idx) begin
            rstn = 1'b0;
            #2;
            checkResetState();
            aborted = 1;
            break;
         end
         if (!stalled && stall_idx >= 0 && cpu_stall && !dump_valid && reg_sel == stall_idx) begin
            dump_ready = 1'b0;
            stalled = 1;
            left = stall_len;
         end else if (left > 0) begin
            checkOutput("stall_valid", dump_valid, 1);
            checkOutput("stall_idx", dump_idx, 64'(stall_idx));
            checkOutput("stall_data", dump_data, expData(stall_idx));
            left--;
            if (left == 0) dump_ready = 1'b1;
         end
         if (dump_valid && dump_ready) begin
            checkOutput("beat_idx", dump_idx, 64'(nb));
            checkOutput("beat_data", dump_data, expData(nb));
            checkOutput("done_early", done, 0);
            nb++;
            if (nb == NREGS) last = 1;
         end
      end
      if (!aborted) checkOutput("dump_beats", 64'(nb), 64'(NREGS));
   endtask

   task automatic checkDoneFrozen();
      checkOutput("done_set", done, 1);
      checkOutput("done_stall", cpu_stall, 1);
      checkOutput("done_valid", dump_valid, 0);
      retire = 1'b1;
      repeat (5) @(negedge clk);
      retire = 1'b0;
      checkOutput("done_sticky", done, 1);
      checkOutput("frozen_cycle_cnt", cycle_cnt, 6);
      checkOutput("frozen_retire_cnt", retire_cnt, 0);
   endtask

   initial begin
      bit ab;
      vecs[0] = '{2'd0, 32'd200, 32'h40, -1, 0, 205, 0, 1'b0};
      vecs[1] = '{2'd2, 32'd0, 32'h40, 17, 0, 23, 0, 1'b0};
      vecs[2] = '{2'd3, 32'd100, 32'h40, 17, 0, 23, 0, 1'b0};
      vecs[3] = '{2'd3, 32'd100, 32'h40, 150, 0, 105, 0, 1'b0};
      vecs[4] = '{2'd1, 32'd10, 32'h40, -1, 1, 25, 12, 1'b0};
      vecs[5] = '{2'd1, 32'd0, 32'h40, -1, 2, 300, 300, 1'b1};
      vecs[6] = '{2'd0, 32'd1, 32'h40, -1, 0, 6, 0, 1'b0};

      for (int i = 0; i < 7; i++) begin
         $display("[TB] vector %0d: mode %0d limit %0d", i, vecs[i].mode, vecs[i].limit);
         applyStimulus(vecs[i]);
      end

      $display("[TB] dump with ready stall at idx 7");
      applyStimulus(vecs[6]);
      runDump(7, 11, -1, ab);
      checkDoneFrozen();
      checkOutput("sat_cycle_cnt", s_cycle_cnt, 15);
      checkOutput("sat_retire_cnt", s_retire_cnt, 15);
      checkOutput("sat_no_stall", s_cpu_stall, 0);

      $display("[TB] reset during dump at idx 12");
      applyStimulus(vecs[6]);
      runDump(-1, 0, 12, ab);
      checkOutput("abort_hit", ab, 1);
      applyStimulus(vecs[6]);
      runDump(-1, 0, -1, ab);
      checkDoneFrozen();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
